spi_byte_engine: RTL and testbench

Mode-0 SPI master shift engine for the j1_soc: serialises one byte on mosi while capturing one byte from miso. It sits directly downstream of the SPI peripheral register wrapper, consuming its data_in/start writes and producing the data_out/busy/new_data status it reads back. It drives sck and ss to the external SPI device.

---
 rtl/spi_byte_engine_if.sv | 11 +
 rtl/spi_byte_engine.sv | 97 +++++++++
 tb/tb_spi_byte_engine.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_engine_if.sv
// Register-side handshake between the SPI peripheral wrapper and the byte engine.
interface spi_byte_engine_if;
    logic [7:0] data_in;
    logic       start;
    logic       busy;
    logic       new_data;
    logic [7:0] data_out;

    modport master (output data_in, start, input busy, new_data, data_out);
    modport slave  (input data_in, start, output busy, new_data, data_out);
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0 SPI master: shifts one byte out on mosi (MSB first) while capturing one from miso.
module spi_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    spi_byte_engine_if.slave   bus,
    input  logic               miso,
    output logic               mosi,
    output logic               sck,
    output logic               ss
);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] half;
    logic [7:0] tx;
    logic [7:0] rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            half         <= '0;
            tx           <= '0;
            rx           <= '0;
            mosi         <= 1'b0;
            sck          <= 1'b0;
            ss           <= 1'b1;
            bus.busy     <= 1'b0;
            bus.new_data <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.new_data <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SETUP;
                        tx       <= bus.data_in;
                        rx       <= '0;
                        cnt      <= '0;
                        mosi     <= bus.data_in[7];
                        ss       <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_MAX) begin
                        // Entering h=0 is the first sck rise: sample miso now.
                        state <= XFER;
                        cnt   <= '0;
                        half  <= '0;
                        sck   <= 1'b1;
                        rx    <= {rx[6:0], miso};
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                XFER: begin
                    if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        if (half == 4'd15) begin
                            state        <= DONE;
                            half         <= half + 4'd1;
                            sck          <= 1'b0;
                            mosi         <= 1'b0;
                            ss           <= 1'b1;
                            bus.busy     <= 1'b0;
                            bus.new_data <= 1'b1;
                            bus.data_out <= rx;
                        end else begin
                            half <= half + 4'd1;
                            if (!half[0]) begin
                                // Next half is odd: sck falls and mosi advances.
                                sck  <= 1'b0;
                                tx   <= {tx[6:0], 1'b0};
                                mosi <= tx[6];
                            end else begin
                                sck <= 1'b1;
                                rx  <= {rx[6:0], miso};
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: loopback, slave model, start filtering, reset abort, back-to-back.
module tb_spi_byte_engine;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_byte_engine_if bus ();
    spi_byte_engine_if bus2 ();
    logic miso, mosi, sck, ss;
    logic miso2, mosi2, sck2, ss2;

    spi_byte_engine #(.CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .miso(miso), .mosi(mosi), .sck(sck), .ss(ss)
    );
    spi_byte_engine #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .miso(miso2), .mosi(mosi2), .sck(sck2), .ss(ss2)
    );

    int compared = 0;
    int mismatched = 0;

    // Device model: counts sck rises within a frame, captures mosi at each rise.
    logic       loop = 1'b1;
    logic [7:0] slv = 8'h00;
    int         rc = 0;
    int         rises = 0;
    int         nd_cnt = 0;
    logic [7:0] mosi_cap = 8'h00;

    always @(posedge sck or posedge ss) begin
        if (ss) rc <= 0;
        else begin
            rc       <= rc + 1;
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[6:0], mosi};
        end
    end
    assign miso  = loop ? mosi : slv[3'd7 - 3'(rc)];
    assign miso2 = mosi2;

    always @(negedge clk) if (bus.new_data === 1'b1) nd_cnt <= nd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] d, input logic [7:0] exp, input bit pester, input string tag);
        int r0, n0, n;
        @(negedge clk);
        bus.data_in = d;
        bus.start   = 1'b1;
        r0 = rises;
        n0 = nd_cnt;
        @(posedge clk); #1;
        chk({tag, " busy@E"}, 32'(bus.busy), 32'd1);
        chk({tag, " ss@E"}, 32'(ss), 32'd0);
        chk({tag, " mosi7@E"}, 32'(mosi), 32'(d[7]));
        bus.start = 1'b0;
        n = 0;
        while (bus.new_data !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (pester && n < 60) begin
                bus.start   = n[0];
                bus.data_in = 8'hFF;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd68);
        chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
        chk({tag, " ss@done"}, 32'(ss), 32'd1);
        chk({tag, " data_out"}, 32'(bus.data_out), 32'(exp));
        chk({tag, " mosi bits"}, 32'(mosi_cap), 32'(d));
        chk({tag, " sck rises"}, 32'(rises - r0), 32'd8);
        @(posedge clk); #1;
        chk({tag, " pulse width"}, 32'(bus.new_data), 32'd0);
        chk({tag, " pulse count"}, 32'(nd_cnt - n0), 32'd1);
    endtask

    initial begin
        int n, nd0, p, last, hi;
        logic [7:0] b [3];
        b = '{8'h11, 8'h22, 8'h33};

        // Reset with random inputs applied.
        rst = 1'b0;
        bus.start = 1'b0; bus.data_in = 8'h00;
        bus2.start = 1'b0; bus2.data_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.start   = 1'($urandom);
            bus.data_in = 8'($urandom);
        end
        #1;
        chk("rst ss", 32'(ss), 32'd1);
        chk("rst sck", 32'(sck), 32'd0);
        chk("rst mosi", 32'(mosi), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst new_data", 32'(bus.new_data), 32'd0);
        chk("rst data_out", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post-rst idle ss", 32'(ss), 32'd1);
        chk("post-rst idle busy", 32'(bus.busy), 32'd0);

        loop = 1'b1;
        xfer(8'hA5, 8'hA5, 1'b0, "loop A5");

        loop = 1'b0; slv = 8'h3C;
        xfer(8'hC3, 8'h3C, 1'b0, "slave C3/3C");

        loop = 1'b1;
        xfer(8'h12, 8'h12, 1'b1, "pester 12");
        repeat (4) @(posedge clk);
        #1;
        chk("pester stays idle", 32'(ss), 32'd1);

        // Abort a 0x5A transfer at the 4th sck rise.
        @(negedge clk);
        bus.data_in = 8'h5A; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        nd0 = nd_cnt;
        n = 0;
        while (rc < 4 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort reached rise4", 32'(rc), 32'd4);
        rst = 1'b0;
        #1;
        chk("abort ss", 32'(ss), 32'd1);
        chk("abort sck", 32'(sck), 32'd0);
        chk("abort mosi", 32'(mosi), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort new_data", 32'(bus.new_data), 32'd0);
        chk("abort data_out", 32'(bus.data_out), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        chk("abort no pulse", 32'(nd_cnt - nd0), 32'd0);
        xfer(8'h81, 8'h81, 1'b0, "after abort 81");

        // CLK_DIV=2 with start held high.
        @(negedge clk);
        bus2.data_in = b[0]; bus2.start = 1'b1;
        p = 0; last = 0; hi = 0;
        for (int c = 1; c <= 200 && p < 3; c++) begin
            @(posedge clk); #1;
            if (bus2.new_data === 1'b1) begin
                chk("b2b data_out", 32'(bus2.data_out), 32'(b[p]));
                if (p > 0) chk("b2b spacing", 32'(c - last), 32'd36);
                last = c;
                p++;
                if (p < 3) bus2.data_in = b[p];
                hi = 0;
            end
            if (ss2 === 1'b1) hi++;
            else if (hi != 0) begin
                chk("b2b ss gap", 32'(hi), 32'd2);
                hi = 0;
            end
        end
        bus2.start = 1'b0;
        chk("b2b pulses", 32'(p), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
